seven_seg_scan_ctrl: RTL and testbench
======================================

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits (2..8).
REQ-002 Parameter BIN_WIDTH, default 14, width of binary input (BIN_WIDTH >= 4*NUM_DIGITS not required).
REQ-003 Parameter REFRESH_BITS, default 18, digit dwell = 2^REFRESH_BITS clk cycles.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 num  input  BIN_WIDTH  binary value to display, sampled only on accepted load.
REQ-007 load  input  1  request to capture num and mode inputs; accepted when busy=0.
REQ-008 hex_mode  input  1  sampled with load: 1 = hexadecimal digits, 0 = decimal (BCD).
REQ-009 blank_lz  input  1  sampled with load: 1 = blank leading zero digits.
REQ-010 dp_mask  input  NUM_DIGITS  sampled with load: bit k lights decimal point of digit k (0 = least significant).
REQ-011 busy  output  1  high while a conversion is in progress.
REQ-012 Anode  output  NUM_DIGITS  active-low digit enables; bit NUM_DIGITS-1 = leftmost digit.
REQ-013 LED_out  output  7  active-low segments, bit6..bit0 = a..g.
REQ-014 dp_out  output  1  active-low decimal point of the currently enabled digit.

Function
REQ-015 Free-running refresh counter of REFRESH_BITS+ceil(log2(NUM_DIGITS)) bits; upper bits form scan index; index wraps from NUM_DIGITS-1 to 0 (counter reloads 0, non-power-of-two NUM_DIGITS supported).
REQ-016 Scan index 0 enables the most significant digit; index i drives Anode bit NUM_DIGITS-1-i low, all others high; exactly one Anode bit low at any time after reset.
REQ-017 Accepted load (load=1, busy=0) captures num, hex_mode, blank_lz, dp_mask into working registers; load while busy=1 is ignored with no side effect.
REQ-018 Decimal mode: iterative shift-add-3 conversion, one input bit per cycle; busy high for exactly BIN_WIDTH cycles starting the cycle after acceptance.
REQ-019 Hex mode: digit k = num[4k+3:4k] (zero-extended); busy high for exactly 1 cycle.
REQ-020 Display digit registers and display flags update atomically in the cycle busy falls; the previous value remains displayed throughout conversion.
REQ-021 Decimal overflow: if num > 10^NUM_DIGITS - 1, every digit shows "-" (LED_out = 7'b1111110), dp off; hex overflow: bits above 4*NUM_DIGITS are ignored.
REQ-022 Segment encoding: 0..9 per standard active-low table ("0" = 7'b0000001, "8" = 7'b0000000); A..F = 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
REQ-023 Leading-zero blanking: when flag set, zero digits more significant than the first non-zero digit show LED_out = 7'b1111111; least significant digit is never blanked; Anode scan continues unchanged.
REQ-024 dp_out low only when the enabled digit's dp_mask bit is 1 and the display is not in overflow.
REQ-025 Anode, LED_out, dp_out are registered (one-cycle delay from scan index), glitch-free on digit change.

Reset
REQ-026 On rst: refresh counter, scan index, busy = 0; digit registers = 0; flags (hex, blank, dp_mask, overflow) = 0; Anode = all ones; LED_out = 7'b1111111; dp_out = 1.
REQ-027 First clock after rst release drives index 0 (leftmost digit, showing "0").
REQ-028 rst asserted mid-conversion aborts it; display registers return to 0, no partial result ever appears.

Structure
REQ-029 Shared package holds segment constants (SEG_BLANK, SEG_DASH, hex-to-segment table function) and the clog2-based index width helper.
REQ-030 One sub-module, bin2bcd_seq, implements the iterative converter with start/done handshake and overflow flag; scan, blanking and segment decode stay in the top.

Verification (REFRESH_BITS=2 in bench)
REQ-031 Decimal load num=1234, blank_lz=0 -> busy high 14 cycles; scan shows 1,2,3,4 left-to-right, Anode 0111,1011,1101,1110.
REQ-032 num=7, blank_lz=1, dp_mask=0010 -> digits blank,blank,blank,"7"; dp_out low only while Anode=1101.
REQ-033 hex_mode=1, num=14'h2BEF -> busy 1 cycle; digits 2? (14-bit: 2,B,E,F) segments 0010010,1100000,0110000,0111000.
REQ-034 num=10000 decimal -> all four digits 1111110, dp_out high.
REQ-035 load=1 held while busy with num changing -> only first value displayed; rst pulse mid-conversion -> LED_out 1111111 during reset, then "0000" display, busy=0.

Source files
------------

// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared segment constants and sizing helpers for the seven-segment scan controller.
package seven_seg_scan_ctrl_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    // Active-low segments, bit6..bit0 = a..g
    function automatic logic [6:0] hex_to_seg(input logic [3:0] val);
        logic [6:0] seg;
        case (val)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_bin2bcd_seq.sv
// Iterative shift-add-3 binary to BCD converter: BIN_WIDTH cycles after start, done is a
// one-cycle strobe with the final digits on bcd_o; start is ignored while busy.
module bin2bcd_seq
    import seven_seg_scan_ctrl_pkg::*;
#(
    parameter int BIN_WIDTH  = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [BIN_WIDTH-1:0]    bin_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [4*NUM_DIGITS-1:0] bcd_o,
    output logic                    ovf_o
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam longint unsigned DEC_MAX = pow10(NUM_DIGITS) - 64'd1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_WIDTH - 1);

    logic                 busy_q, busy_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIN_WIDTH-1:0] sh_q, sh_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic                 ovf_q, ovf_d;
    logic [BCD_W-1:0]     adj;

    always_comb begin
        adj = bcd_q;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (bcd_q[4*d +: 4] > 4'd4) adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
        end
        busy_d = busy_q;
        cnt_d  = cnt_q;
        sh_d   = sh_q;
        bcd_d  = bcd_q;
        ovf_d  = ovf_q;
        if (busy_q) begin
            bcd_d = {adj[BCD_W-2:0], sh_q[BIN_WIDTH-1]};
            sh_d  = sh_q << 1;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == '0) busy_d = 1'b0;
        end else if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = LAST_CNT;
            sh_d   = bin_i;
            bcd_d  = '0;
            // Out-of-range values cannot be shown; the digits shifted in are then don't-care
            ovf_d  = (64'(bin_i) > DEC_MAX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            sh_q   <= '0;
            bcd_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            sh_q   <= sh_d;
            bcd_q  <= bcd_d;
            ovf_q  <= ovf_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == '0);
    assign bcd_o  = bcd_d;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment driver: load accepted when idle, display swaps atomically when busy
// falls; scan outputs are registered one cycle behind the free-running refresh counter.
module seven_seg_scan_ctrl
    import seven_seg_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int BIN_WIDTH    = 14,
    parameter int REFRESH_BITS = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIN_WIDTH-1:0]  num,
    input  logic                  load,
    input  logic                  hex_mode,
    input  logic                  blank_lz,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic                  busy,
    output logic [NUM_DIGITS-1:0] Anode,
    output logic [6:0]            LED_out,
    output logic                  dp_out
);
    localparam int IDX_W = idx_width(NUM_DIGITS);
    localparam int CNT_W = REFRESH_BITS + IDX_W;
    localparam int DIG_W = 4 * NUM_DIGITS;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((longint'(NUM_DIGITS) << REFRESH_BITS) - 64'd1);

    logic [CNT_W-1:0]      refresh_q, refresh_d;
    logic                  hex_busy_q, hex_busy_d;
    logic [DIG_W-1:0]      num_q, num_d;
    logic                  blank_q, blank_d;
    logic [NUM_DIGITS-1:0] dpm_q, dpm_d;
    logic [DIG_W-1:0]      disp_dig_q, disp_dig_d;
    logic                  disp_blank_q, disp_blank_d;
    logic [NUM_DIGITS-1:0] disp_dpm_q, disp_dpm_d;
    logic                  disp_ovf_q, disp_ovf_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [6:0]            led_q, led_d;
    logic                  dp_q, dp_d;

    logic                  accept;
    logic                  conv_busy, conv_done, conv_ovf;
    logic [DIG_W-1:0]      conv_bcd;
    logic [IDX_W-1:0]      idx;
    logic [NUM_DIGITS-1:0] lz;
    logic                  run;

    assign busy   = conv_busy || hex_busy_q;
    assign accept = load && !busy;

    bin2bcd_seq #(
        .BIN_WIDTH  (BIN_WIDTH),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .start_i (accept && !hex_mode),
        .bin_i   (num),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd),
        .ovf_o   (conv_ovf)
    );

    always_comb begin
        refresh_d    = (refresh_q == CNT_LAST) ? '0 : refresh_q + CNT_W'(1);
        hex_busy_d   = 1'b0;
        num_d        = num_q;
        blank_d      = blank_q;
        dpm_d        = dpm_q;
        disp_dig_d   = disp_dig_q;
        disp_blank_d = disp_blank_q;
        disp_dpm_d   = disp_dpm_q;
        disp_ovf_d   = disp_ovf_q;
        if (accept) begin
            hex_busy_d = hex_mode;
            num_d      = DIG_W'(num);
            blank_d    = blank_lz;
            dpm_d      = dp_mask;
        end
        // Hex digits are a straight nibble slice, so the swap happens one cycle after accept
        if (hex_busy_q) begin
            disp_dig_d   = num_q;
            disp_ovf_d   = 1'b0;
            disp_blank_d = blank_q;
            disp_dpm_d   = dpm_q;
        end else if (conv_done) begin
            disp_dig_d   = conv_bcd;
            disp_ovf_d   = conv_ovf;
            disp_blank_d = blank_q;
            disp_dpm_d   = dpm_q;
        end
    end

    always_comb begin
        idx = refresh_q[CNT_W-1 -: IDX_W];
        run = 1'b1;
        lz  = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            run   = run && (disp_dig_q[4*k +: 4] == 4'd0);
            lz[k] = run && (k != 0) && disp_blank_q;
        end
        anode_d = '1;
        led_d   = SEG_BLANK;
        dp_d    = 1'b1;
        // Scan index 0 is the leftmost (most significant) digit
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (int'(idx) == NUM_DIGITS - 1 - k) begin
                anode_d[k] = 1'b0;
                if (disp_ovf_q)  led_d = SEG_DASH;
                else if (lz[k])  led_d = SEG_BLANK;
                else             led_d = hex_to_seg(disp_dig_q[4*k +: 4]);
                dp_d = !(disp_dpm_q[k] && !disp_ovf_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_q    <= '0;
            hex_busy_q   <= 1'b0;
            num_q        <= '0;
            blank_q      <= 1'b0;
            dpm_q        <= '0;
            disp_dig_q   <= '0;
            disp_blank_q <= 1'b0;
            disp_dpm_q   <= '0;
            disp_ovf_q   <= 1'b0;
            anode_q      <= '1;
            led_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
        end else begin
            refresh_q    <= refresh_d;
            hex_busy_q   <= hex_busy_d;
            num_q        <= num_d;
            blank_q      <= blank_d;
            dpm_q        <= dpm_d;
            disp_dig_q   <= disp_dig_d;
            disp_blank_q <= disp_blank_d;
            disp_dpm_q   <= disp_dpm_d;
            disp_ovf_q   <= disp_ovf_d;
            anode_q      <= anode_d;
            led_q        <= led_d;
            dp_q         <= dp_d;
        end
    end

    assign Anode   = anode_q;
    assign LED_out = led_q;
    assign dp_out  = dp_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: loads push expected displays, a negedge monitor checks the scan.
module tb_seven_seg_scan_ctrl;
    localparam int ND = 4;
    localparam int BW = 14;
    localparam int RB = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [BW-1:0] num = '0;
    logic          load = 1'b0;
    logic          hex_mode = 1'b0;
    logic          blank_lz = 1'b0;
    logic [ND-1:0] dp_mask = '0;
    logic          busy;
    logic [ND-1:0] Anode;
    logic [6:0]    LED_out;
    logic          dp_out;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .BIN_WIDTH    (BW),
        .REFRESH_BITS (RB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .num      (num),
        .load     (load),
        .hex_mode (hex_mode),
        .blank_lz (blank_lz),
        .dp_mask  (dp_mask),
        .busy     (busy),
        .Anode    (Anode),
        .LED_out  (LED_out),
        .dp_out   (dp_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][6:0] seg;
        logic [3:0]      dp;
        int              blen;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tot++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    endtask

    function automatic logic [6:0] seg_of(input int unsigned d);
        case (d)
            0:  return 7'b0000001;
            1:  return 7'b1001111;
            2:  return 7'b0010010;
            3:  return 7'b0000110;
            4:  return 7'b1001100;
            5:  return 7'b0100100;
            6:  return 7'b0100000;
            7:  return 7'b0001111;
            8:  return 7'b0000000;
            9:  return 7'b0000100;
            10: return 7'b0001000;
            11: return 7'b1100000;
            12: return 7'b0110001;
            13: return 7'b1000010;
            14: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    // Display content derived arithmetically from the value: digit k = (v / base^k) mod base
    function automatic exp_t model(input int unsigned v, input bit hx, input bit bl,
                                   input logic [3:0] dpm);
        exp_t        e;
        int unsigned base;
        int unsigned p;
        bit          ovf;
        base = hx ? 16 : 10;
        p    = 1;
        ovf  = !hx && (v > 9999);
        for (int k = 0; k < ND; k++) begin
            e.seg[k] = seg_of((v / p) % base);
            if (bl && k > 0 && v < p) e.seg[k] = 7'b1111111;
            if (ovf) e.seg[k] = 7'b1111110;
            e.dp[k] = !(dpm[k] && !ovf);
            p = p * base;
        end
        e.blen = hx ? 1 : BW;
        return e;
    endfunction

    int n_edge;
    always @(posedge clk or posedge rst) begin
        if (rst) n_edge <= 0;
        else     n_edge <= n_edge + 1;
    end

    exp_t cur, pend;
    bit   upd_next  = 1'b0;
    bit   prev_busy = 1'b0;
    int   bcnt      = 0;
    initial cur = model(0, 1'b0, 1'b0, 4'b0000);

    always @(negedge clk) begin : monitor
        int         idx;
        logic [3:0] ea;
        if (rst) begin
            cur       = model(0, 1'b0, 1'b0, 4'b0000);
            upd_next  = 1'b0;
            prev_busy = 1'b0;
            bcnt      = 0;
        end else begin
            if (upd_next) begin
                cur      = pend;
                upd_next = 1'b0;
            end
            if (n_edge >= 1) begin
                idx = ((n_edge - 1) / (1 << RB)) % ND;
                ea  = 4'b1111;
                ea[ND-1-idx] = 1'b0;
                chk("anode", 32'(Anode), 32'(ea));
                chk("led", 32'(LED_out), 32'(cur.seg[ND-1-idx]));
                chk("dp", 32'(dp_out), 32'(cur.dp[ND-1-idx]));
            end
            if (busy) begin
                bcnt++;
            end else if (prev_busy) begin
                chk("sb_pending", 32'(sb.size()), 32'd1);
                if (sb.size() > 0) begin
                    pend = sb.pop_front();
                    chk("busy_len", 32'(bcnt), 32'(pend.blen));
                    upd_next = 1'b1;
                end
                bcnt = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 200) begin
            tick();
            k++;
        end
        chk("busy_clears", 32'(busy), 32'd0);
    endtask

    task automatic do_load(input int unsigned v, input bit hx, input bit bl, input logic [3:0] dm);
        num      = BW'(v);
        hex_mode = hx;
        blank_lz = bl;
        dp_mask  = dm;
        load     = 1'b1;
        sb.push_back(model(v % (1 << BW), hx, bl, dm));
        tick();
        load = 1'b0;
        chk("busy_after_load", 32'(busy), 32'd1);
        wait_idle();
        repeat (ND * (1 << RB) + 4) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : driver
        int k;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_anode", 32'(Anode), 32'hF);
        chk("rst_led", 32'(LED_out), 32'h7F);
        chk("rst_dp", 32'(dp_out), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) tick();

        do_load(1234, 1'b0, 1'b0, 4'b0000);
        do_load(7, 1'b0, 1'b1, 4'b0010);
        do_load(14'h2BEF, 1'b1, 1'b0, 4'b0000);
        do_load(10000, 1'b0, 1'b0, 4'b1111);
        do_load(9999, 1'b0, 1'b1, 4'b1010);
        do_load(0, 1'b0, 1'b1, 4'b0001);
        do_load(0, 1'b1, 1'b1, 4'b0000);
        do_load(14'h3FFF, 1'b1, 1'b0, 4'b0101);
        do_load(100, 1'b0, 1'b1, 4'b0100);

        // load held high with changing inputs while busy: only the first value may appear
        num      = BW'(555);
        hex_mode = 1'b0;
        blank_lz = 1'b0;
        dp_mask  = 4'b0011;
        load     = 1'b1;
        sb.push_back(model(555, 1'b0, 1'b0, 4'b0011));
        tick();
        k = 0;
        while (busy && k < 100) begin
            num      = BW'($urandom);
            dp_mask  = 4'($urandom);
            blank_lz = 1'($urandom);
            hex_mode = 1'($urandom);
            tick();
            k++;
        end
        load = 1'b0;
        chk("held_busy_clears", 32'(busy), 32'd0);
        repeat (ND * (1 << RB) + 4) tick();

        for (int i = 0; i < 12; i++) begin
            int unsigned v;
            bit          hx;
            bit          bl;
            logic [3:0]  dm;
            v  = (i % 4 == 0) ? $urandom_range(9990, 10010) : $urandom_range(0, 16383);
            hx = (i % 4 == 0) ? 1'b0 : 1'($urandom);
            bl = 1'($urandom);
            dm = 4'($urandom);
            do_load(v, hx, bl, dm);
        end

        // reset in the middle of a decimal conversion
        num      = BW'(4321);
        hex_mode = 1'b0;
        blank_lz = 1'b1;
        dp_mask  = 4'b1111;
        load     = 1'b1;
        tick();
        load = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("midrst_anode", 32'(Anode), 32'hF);
        chk("midrst_led", 32'(LED_out), 32'h7F);
        chk("midrst_dp", 32'(dp_out), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        repeat (ND * (1 << RB) + 4) tick();
        chk("post_rst_busy", 32'(busy), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
